mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline register for the pipelined MIPS core; replaces the single-cycle write-back mux.
- Selects write-back data (ALU result, extended load data or link address) in the MEM stage and registers it.
- Registers destination and write enable with stall/flush control.
- Also exposes the registered result as a forwarding source and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width; must be ≥16 and a multiple of 8.
- REG_AW, 5, register-file address width.
- LINK_OFFSET, 8, value added to PC for link write-back (delay slot).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble.
- in_valid  in  1  MEM stage holds a real instruction.
- in_alu_result  in  DATA_W  ALU result / memory address.
- in_read_data  in  DATA_W  raw word from data memory.
- in_pc  in  DATA_W  PC of the instruction.
- in_mem_to_reg  in  2  0=ALU, 1=load, 2=link, 3=zero.
- in_load_type  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU, others=LW.
- in_reg_write  in  1  instruction writes the register file.
- in_rd  in  REG_AW  destination register.
- wb_valid  out  1  registered valid.
- wb_we  out  1  register-file write enable.
- wb_addr  out  REG_AW  register-file write address.
- wb_data  out  DATA_W  register-file write data.
- fwd_hit_en  out  1  forwarding source valid; equals wb_we.
- retired_count  out  CNT_W  instructions retired since reset.

Behaviour:
- Priority on each rising clk edge: reset > flush > stall > normal load.
- Reset:
  - wb_valid=0, wb_we=0, wb_addr=0, wb_data=0, retired_count=0.
  - Reset mid-stall or mid-flush still clears everything.
- Flush: same clears as reset except retired_count, which holds. Flush with stall asserted still inserts the bubble.
- Stall (no flush): every register holds, retired_count included.
- Normal load (latency 1):
  - wb_valid <= in_valid.
  - wb_addr <= in_rd.
  - wb_we <= in_valid & in_reg_write & (in_rd != 0); writes to $0 are suppressed.
  - wb_data <= selected value (below).
  - retired_count <= retired_count + in_valid, wrapping modulo 2^CNT_W.
- Data select, combinational, before the register:
  - mem_to_reg 0: in_alu_result.
  - mem_to_reg 1: load-extended value.
  - mem_to_reg 2: in_pc + LINK_OFFSET, truncated to DATA_W (wraps).
  - mem_to_reg 3: 0.
- Load extension:
  - off = in_alu_result[1:0].
  - Byte = in_read_data[8*off +: 8].
  - Half = in_read_data[16*off[1] +: 16]; off[0] is ignored and no alignment exception is raised here.
  - LB/LH sign-extend to DATA_W; LBU/LHU zero-extend; LW and undefined codes pass the word through.
- When in_valid=0, data is still latched but wb_we=0.
- fwd_hit_en is identical to wb_we. Downstream forwarding compares wb_addr and uses wb_data.
- No combinational path from any input to any output.

Decomposition:
- Shared package (cpu_defs):
  - MEMTOREG_ALU/LOAD/LINK/ZERO constants.
  - LOAD_LW/LB/LBU/LH/LHU codes.
  - The defaults for DATA_W and REG_AW.
- One natural sub-module: load_ext (combinational byte/half select plus sign/zero extension, parametrised on DATA_W). The stage instantiates it and keeps the select mux and registers local.

Test Plan:
- Reset: hold reset 2 cycles with random inputs, in_valid=1 -> all outputs 0, retired_count=0. Release and load ALU=0x1234_5678, rd=3, reg_write=1 -> next cycle wb_we=1, wb_addr=3, wb_data=0x12345678, retired_count=1.
- Load extension: read_data=0x80FF_7F01.
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Link and $0: mem_to_reg=2, pc=0x0000_3000 -> wb_data=0x00003008. pc=0xFFFF_FFFC -> 0x00000004 (wrap). rd=0 with reg_write=1 -> wb_we=0, wb_valid=1.
- Stall/flush:
  - Load A, then assert stall 3 cycles with input B -> outputs stay A and retired_count is unchanged.
  - Assert stall+flush together -> bubble: wb_valid=0, wb_we=0, wb_data=0, count held.
- Counter wrap: CNT_W=4, feed 17 valid instructions interleaved with 5 invalid ones -> retired_count=1.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS core definitions: write-back select codes,
// load-type codes and default datapath widths.
package cpu_defs;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] MEMTOREG_ALU  = 2'd0;
  localparam logic [1:0] MEMTOREG_LOAD = 2'd1;
  localparam logic [1:0] MEMTOREG_LINK = 2'd2;
  localparam logic [1:0] MEMTOREG_ZERO = 2'd3;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH  = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load extension: picks byte/half out of the fetched word
// and sign/zero extends it; words pass through.
module load_ext
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select; half ignores off[0] (no alignment trap here)
  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = rdata[16*off[1] +: 16];
  end

  // Extend the selected lane according to the load kind
  always_comb begin
    ext = rdata;
    unique case (load_type)
      LOAD_LB:  ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: ext = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_LH:  ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: ext = {{(DATA_W-16){1'b0}}, half_sel};
      default:  ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back select, stall/flush,
// forwarding source and retired-instruction counter.
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LINK_OFFSET = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [1:0]        in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_hit_en,
  output logic [CNT_W-1:0]  retired_count
);

  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] sel_data;

  logic              valid_d, valid_q;
  logic              we_d,    we_q;
  logic [REG_AW-1:0] addr_d,  addr_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [CNT_W-1:0]  cnt_d,   cnt_q;

  load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .off      (in_alu_result[1:0]),
    .rdata    (in_read_data),
    .load_type(in_load_type),
    .ext      (load_val)
  );

  // Write-back source select ahead of the register
  always_comb begin
    sel_data = '0;
    unique case (in_mem_to_reg)
      MEMTOREG_ALU:  sel_data = in_alu_result;
      MEMTOREG_LOAD: sel_data = load_val;
      MEMTOREG_LINK: sel_data = in_pc + DATA_W'(LINK_OFFSET);
      MEMTOREG_ZERO: sel_data = '0;
      default:       sel_data = '0;
    endcase
  end

  // Next state: reset > flush > stall > load
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (reset) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      cnt_d   = '0;
    end else if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      we_d    = in_valid & in_reg_write
              & (in_rd != '0);
      addr_d  = in_rd;
      data_d  = sel_data;
      cnt_d   = cnt_q + CNT_W'(in_valid);
    end
  end

  // Stage registers; reset folded into next-state logic
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
    cnt_q   <= cnt_d;
  end

  // Outputs come straight from flops
  always_comb begin
    wb_valid      = valid_q;
    wb_we         = we_q;
    wb_addr       = addr_q;
    wb_data       = data_q;
    fwd_hit_en    = we_q;
    retired_count = cnt_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random traffic
// checked against a spec-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_alu_result, in_read_data, in_pc;
  logic [1:0]  in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic        in_reg_write;
  logic [4:0]  in_rd;

  logic        wb_valid, wb_we, fwd_hit_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, retired_count;

  logic        wb_valid4, wb_we4, fwd_hit_en4;
  logic [4:0]  wb_addr4;
  logic [31:0] wb_data4;
  logic [3:0]  retired_count4;

  int total = 0;
  int fails = 0;

  bit          m_valid, m_we;
  int unsigned m_addr, m_data, m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_read_data(in_read_data), .in_pc(in_pc),
    .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .in_reg_write(in_reg_write), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .fwd_hit_en(fwd_hit_en),
    .retired_count(retired_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_read_data(in_read_data), .in_pc(in_pc),
    .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .in_reg_write(in_reg_write), .in_rd(in_rd),
    .wb_valid(wb_valid4), .wb_we(wb_we4), .wb_addr(wb_addr4),
    .wb_data(wb_data4), .fwd_hit_en(fwd_hit_en4),
    .retired_count(retired_count4)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_load(int unsigned w, int unsigned a,
                                           int unsigned t);
    int unsigned off, b, h;
    off = a % 4;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2: return b;
      3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4: return h;
      default: return w;
    endcase
  endfunction

  function automatic int unsigned ref_data();
    case (in_mem_to_reg)
      2'd0: return in_alu_result;
      2'd1: return ref_load(in_read_data, in_alu_result, in_load_type);
      2'd2: return in_pc + 32'd8;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_valid = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_we    = in_valid && in_reg_write && (in_rd != 0);
      m_addr  = in_rd;
      m_data  = ref_data();
      m_cnt   = m_cnt + (in_valid ? 1 : 0);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(m_valid));
    chk({tag, ".we"},    32'(wb_we),    32'(m_we));
    chk({tag, ".fwd"},   32'(fwd_hit_en), 32'(m_we));
    chk({tag, ".addr"},  32'(wb_addr),  m_addr);
    chk({tag, ".data"},  wb_data,       m_data);
    chk({tag, ".cnt"},   retired_count, m_cnt);
    chk({tag, ".cnt4"},  32'(retired_count4), m_cnt % 16);
    chk({tag, ".data4"}, wb_data4,      m_data);
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic rand_in();
    in_valid      = 1'($urandom);
    in_alu_result = $urandom;
    in_read_data  = $urandom;
    in_pc         = $urandom;
    in_mem_to_reg = 2'($urandom);
    in_load_type  = 3'($urandom_range(0, 7));
    in_reg_write  = 1'($urandom);
    in_rd         = 5'($urandom);
  endtask

  task automatic set_load(logic [1:0] off, logic [2:0] lt);
    in_valid = 1; in_reg_write = 1; in_rd = 5'd7;
    in_mem_to_reg = 2'd1; in_read_data = 32'h80FF_7F01;
    in_alu_result = {30'h100, off}; in_load_type = lt;
  endtask

  initial begin
    int unsigned a_data, a_cnt;
    logic [2:0]  lt_tab  [5];
    logic [1:0]  off_tab [5];
    logic [31:0] exp_tab [5];
    lt_tab  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    off_tab = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
    exp_tab = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                32'h0000_7F01, 32'h80FF_7F01};

    m_valid = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    reset = 1; stall = 0; flush = 0;
    rand_in();
    #1;
    for (int i = 0; i < 2; i++) begin
      rand_in(); in_valid = 1; stall = 1'($urandom);
      cyc("reset");
    end
    chk("reset.data0", wb_data, 32'h0);
    chk("reset.cnt0", retired_count, 32'h0);

    reset = 0; stall = 0;
    in_valid = 1; in_alu_result = 32'h1234_5678; in_mem_to_reg = 0;
    in_rd = 3; in_reg_write = 1;
    cyc("first");
    chk("first.we", 32'(wb_we), 32'h1);
    chk("first.addr", 32'(wb_addr), 32'h3);
    chk("first.data", wb_data, 32'h1234_5678);
    chk("first.cnt", retired_count, 32'h1);

    for (int i = 0; i < 5; i++) begin
      set_load(off_tab[i], lt_tab[i]);
      cyc("ldx");
      chk("ldx.const", wb_data, exp_tab[i]);
    end

    in_mem_to_reg = 2'd2; in_pc = 32'h0000_3000;
    cyc("link");
    chk("link.const", wb_data, 32'h0000_3008);
    in_pc = 32'hFFFF_FFFC;
    cyc("linkwrap");
    chk("linkwrap.const", wb_data, 32'h0000_0004);
    in_rd = 0; in_reg_write = 1; in_valid = 1; in_mem_to_reg = 0;
    cyc("rd0");
    chk("rd0.we", 32'(wb_we), 32'h0);
    chk("rd0.valid", 32'(wb_valid), 32'h1);

    rand_in(); in_valid = 1; in_rd = 5'd9; in_reg_write = 1;
    cyc("loadA");
    a_data = m_data; a_cnt = m_cnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_in(); in_valid = 1;
      cyc("stall");
      chk("stall.holdA", wb_data, a_data);
      chk("stall.holdcnt", retired_count, a_cnt);
      chk("stall.we", 32'(wb_we), 32'h1);
    end
    flush = 1;
    cyc("bubble");
    chk("bubble.valid", 32'(wb_valid), 32'h0);
    chk("bubble.data", wb_data, 32'h0);
    chk("bubble.cnt", retired_count, a_cnt);
    stall = 0; flush = 0;

    reset = 1;
    cyc("rst2");
    reset = 0;
    begin
      int v = 0, n = 0;
      for (int i = 0; i < 22; i++) begin
        rand_in();
        in_valid = (v < 17) && ((n >= 5) || (i % 4 != 3));
        if (in_valid) v++; else n++;
        cyc("wrap");
      end
    end
    chk("wrap.cnt4", 32'(retired_count4), 32'h1);
    chk("wrap.cnt32", retired_count, 32'd17);

    for (int i = 0; i < 300; i++) begin
      rand_in();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 31) == 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
